// File: rtl/ppu_tile_serializer_if.sv
// ppu_tile_serializer_if
//   Tile hand-off bus into the background tile serializer. One tile is the
//   two bit-plane pattern bytes plus a 2-bit palette select, transferred with
//   a valid/ready handshake. Signal names are from the serializer's view.
//
//   i_tile_valid  producer -> serializer  tile data present
//   o_tile_ready  serializer -> producer  tile can be taken this cycle
//   i_pattern_lo  producer -> serializer  bit-plane 0 byte
//   i_pattern_hi  producer -> serializer  bit-plane 1 byte
//   i_palette     producer -> serializer  attribute palette select
interface ppu_tile_serializer_if;
    logic       i_tile_valid;
    logic       o_tile_ready;
    logic [7:0] i_pattern_lo;
    logic [7:0] i_pattern_hi;
    logic [1:0] i_palette;

    modport master (
        output i_tile_valid,
        output i_pattern_lo,
        output i_pattern_hi,
        output i_palette,
        input  o_tile_ready
    );

    modport slave (
        input  i_tile_valid,
        input  i_pattern_lo,
        input  i_pattern_hi,
        input  i_palette,
        output o_tile_ready
    );
endinterface

// File: rtl/ppu_tile_serializer.sv
// ppu_tile_serializer
//   Parallel-to-serial transmitter for the PPU background pipeline. Takes one
//   tile (two pattern bytes + palette) over the tile bus and streams it LSB
//   first as load/shift strobes plus one serial bit per plane. A one-entry
//   holding buffer lets the next tile arrive while the current one is still
//   going out, so consecutive tiles stream without a gap.
//   All state changes on the falling edge of i_clk.
//
// Ports
//   i_clk, i_reset_n   clock (falling-edge active), async active-low reset
//   tile               tile bus (valid/ready, pattern lo/hi, palette)
//   i_enable           pixel advance, one bit per enabled cycle
//   i_clear_underrun   clears the sticky underrun flag
//   o_load, o_shift    strobes to the plane shift registers
//   o_data_lo/hi       serial bit per plane
//   o_palette          palette of the tile being sent (held in IDLE)
//   o_bit_index        bit currently on o_data_*
//   o_busy             a tile is being sent
//   o_underrun         sticky underrun flag
//
// Build option
//   PPU_TILE_SERIALIZER_UNDERRUN_EN  compiles in underrun detection; without
//   it o_underrun is tied low and i_clear_underrun is ignored.
module ppu_tile_serializer (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    ppu_tile_serializer_if.slave       tile,
    input  logic                       i_enable,
    input  logic                       i_clear_underrun,
    output logic                       o_load,
    output logic                       o_shift,
    output logic                       o_data_lo,
    output logic                       o_data_hi,
    output logic [1:0]                 o_palette,
    output logic [2:0]                 o_bit_index,
    output logic                       o_busy,
    output logic                       o_underrun
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state;
    logic [7:0] act_lo, act_hi;
    logic [1:0] act_pal;
    logic [2:0] bit_cnt;
    logic [7:0] buf_lo, buf_hi;
    logic [1:0] buf_pal;
    logic       buf_valid;
    logic       accept;
    logic       last_bit;

    assign tile.o_tile_ready = !buf_valid;
    assign accept            = tile.i_tile_valid && !buf_valid;
    assign last_bit          = (state == SEND) && i_enable && (bit_cnt == 3'd7);

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            act_lo    <= '0;
            act_hi    <= '0;
            act_pal   <= '0;
            bit_cnt   <= '0;
            buf_lo    <= '0;
            buf_hi    <= '0;
            buf_pal   <= '0;
            buf_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        act_lo  <= tile.i_pattern_lo;
                        act_hi  <= tile.i_pattern_hi;
                        act_pal <= tile.i_palette;
                        bit_cnt <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (last_bit) begin
                        // Handover: a buffered tile wins; ready is low then,
                        // so a same-edge accept cannot also occur.
                        bit_cnt <= '0;
                        if (buf_valid) begin
                            act_lo    <= buf_lo;
                            act_hi    <= buf_hi;
                            act_pal   <= buf_pal;
                            buf_valid <= 1'b0;
                        end else if (accept) begin
                            act_lo  <= tile.i_pattern_lo;
                            act_hi  <= tile.i_pattern_hi;
                            act_pal <= tile.i_palette;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (i_enable)
                            bit_cnt <= bit_cnt + 3'd1;
                        if (accept) begin
                            buf_lo    <= tile.i_pattern_lo;
                            buf_hi    <= tile.i_pattern_hi;
                            buf_pal   <= tile.i_palette;
                            buf_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy      = (state == SEND);
    assign o_load      = o_busy && i_enable;
    // Gated by reset so the strobe is quiet while reset is held.
    assign o_shift     = i_enable && i_reset_n;
    assign o_data_lo   = o_busy && act_lo[bit_cnt];
    assign o_data_hi   = o_busy && act_hi[bit_cnt];
    assign o_palette   = act_pal;
    assign o_bit_index = bit_cnt;

`ifdef PPU_TILE_SERIALIZER_UNDERRUN_EN
    logic seen_tile;
    logic underrun_flag;
    logic underrun_evt;

    // Underrun only counts once the pipeline has been fed at least once.
    assign underrun_evt = (state == IDLE) && i_enable && seen_tile;

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seen_tile     <= 1'b0;
            underrun_flag <= 1'b0;
        end else begin
            if (accept)
                seen_tile <= 1'b1;
            if (i_clear_underrun)
                underrun_flag <= 1'b0;
            else if (underrun_evt)
                underrun_flag <= 1'b1;
        end
    end

    assign o_underrun = underrun_flag;
`else
    logic unused_clear;
    assign unused_clear = i_clear_underrun;
    assign o_underrun   = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_tile_serializer.sv
module tb_ppu_tile_serializer;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_enable;
    logic       i_clear_underrun;
    logic       o_load, o_shift, o_data_lo, o_data_hi, o_busy, o_underrun;
    logic [1:0] o_palette;
    logic [2:0] o_bit_index;

    ppu_tile_serializer_if tif ();

    ppu_tile_serializer dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .tile             (tif.slave),
        .i_enable         (i_enable),
        .i_clear_underrun (i_clear_underrun),
        .o_load           (o_load),
        .o_shift          (o_shift),
        .o_data_lo        (o_data_lo),
        .o_data_hi        (o_data_hi),
        .o_palette        (o_palette),
        .o_bit_index      (o_bit_index),
        .o_busy           (o_busy),
        .o_underrun       (o_underrun)
    );

    initial i_clk = 1'b1;
    always #5 i_clk = ~i_clk;

`ifdef PPU_TILE_SERIALIZER_UNDERRUN_EN
    localparam logic UR_EXP = 1'b1;
`else
    localparam logic UR_EXP = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       valid;
        logic [7:0] lo, hi;
        logic [1:0] pal;
        logic       en;
        logic       ready, load, shift, dlo, dhi;
        logic [1:0] opal;
        logic       busy;
        logic       chk_idx;
        logic [2:0] idx;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic valid, input logic [7:0] lo, input logic [7:0] hi,
                        input logic [1:0] pal, input logic en, input logic ready,
                        input logic dlo, input logic dhi, input logic [1:0] opal,
                        input logic busy, input logic chk_idx, input logic [2:0] idx);
        vec_t v;
        v.valid = valid; v.lo = lo; v.hi = hi; v.pal = pal; v.en = en;
        v.ready = ready; v.load = busy & en; v.shift = en;
        v.dlo = dlo; v.dhi = dhi; v.opal = opal; v.busy = busy;
        v.chk_idx = chk_idx; v.idx = idx;
        tv.push_back(v);
    endtask

    task automatic drive(input logic valid, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [1:0] pal, input logic en, input logic clr);
        tif.i_tile_valid = valid;
        tif.i_pattern_lo = lo;
        tif.i_pattern_hi = hi;
        tif.i_palette    = pal;
        i_enable         = en;
        i_clear_underrun = clr;
    endtask

    // Sample point is the rising edge, halfway between active falling edges.
    task automatic to_sample();
        @(posedge i_clk);
    endtask

    task automatic to_next();
        @(negedge i_clk);
        #1;
    endtask

    initial begin
        logic [7:0] a_lo, a_hi, b_lo;

        // Table: single tile, then back-to-back pair through the buffer.
        addv(1, 8'hA5, 8'h3C, 2, 0, 1, 0, 0, 0, 0, 1, 0);
        a_lo = 8'hA5; a_hi = 8'h3C;
        for (int k = 0; k < 8; k++)
            addv(0, 0, 0, 0, 1, 1, a_lo[k], a_hi[k], 2, 1, 1, 3'(k));
        addv(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
        addv(1, 8'h01, 8'h80, 1, 0, 1, 0, 0, 2, 0, 0, 0);
        a_lo = 8'h01; a_hi = 8'h80;
        addv(1, 8'hFF, 8'h00, 3, 1, 1, a_lo[0], a_hi[0], 1, 1, 1, 0);
        for (int k = 1; k < 8; k++)
            addv(0, 0, 0, 0, 1, 0, a_lo[k], a_hi[k], 1, 1, 1, 3'(k));
        for (int k = 0; k < 8; k++)
            addv(0, 0, 0, 0, 1, 1, 1'b1, 1'b0, 3, 1, 1, 3'(k));
        addv(0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0);
        i_reset_n = 1'b0;
        #2;
        chk("rst_ready", tif.o_tile_ready, 1);
        chk("rst_load", o_load, 0);
        chk("rst_shift", o_shift, 0);
        chk("rst_data", {o_data_lo, o_data_hi}, 0);
        chk("rst_pal", o_palette, 0);
        chk("rst_idx", o_bit_index, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_underrun", o_underrun, 0);
        @(posedge i_clk);
        i_reset_n = 1'b1;
        to_next();

        foreach (tv[i]) begin
            drive(tv[i].valid, tv[i].lo, tv[i].hi, tv[i].pal, tv[i].en, 0);
            to_sample();
            chk($sformatf("v%0d_ready", i), tif.o_tile_ready, tv[i].ready);
            chk($sformatf("v%0d_load", i), o_load, tv[i].load);
            chk($sformatf("v%0d_shift", i), o_shift, tv[i].shift);
            chk($sformatf("v%0d_data", i), {o_data_lo, o_data_hi}, {tv[i].dlo, tv[i].dhi});
            chk($sformatf("v%0d_pal", i), o_palette, tv[i].opal);
            chk($sformatf("v%0d_busy", i), o_busy, tv[i].busy);
            if (tv[i].chk_idx)
                chk($sformatf("v%0d_idx", i), o_bit_index, tv[i].idx);
            to_next();
        end

        // Direct handover: next tile offered exactly on the last-bit edge.
        a_lo = 8'h0F; a_hi = 8'hF0; b_lo = 8'h55;
        drive(1, a_lo, a_hi, 1, 0, 0);
        to_sample(); to_next();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) drive(1, 8'h55, 8'hAA, 2, 1, 0);
            else        drive(0, 0, 0, 0, 1, 0);
            to_sample();
            chk($sformatf("dh_a%0d", k), {o_data_lo, o_data_hi, o_busy}, {a_lo[k], a_hi[k], 1'b1});
            if (k == 7) chk("dh_ready_last", tif.o_tile_ready, 1);
            to_next();
        end
        a_hi = 8'hAA;
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            to_sample();
            chk($sformatf("dh_b%0d", k), {o_data_lo, o_data_hi, o_busy, o_load}, {b_lo[k], a_hi[k], 2'b11});
            chk($sformatf("dh_b%0d_meta", k), {o_palette, o_bit_index}, {2'd2, 3'(k)});
            to_next();
        end
        drive(0, 0, 0, 0, 0, 0);
        to_sample();
        chk("dh_idle", o_busy, 0);
        to_next();

        // Enable toggling: bit counter advances only on enabled cycles.
        a_lo = 8'hC3; a_hi = 8'h5A;
        drive(1, a_lo, a_hi, 0, 0, 0);
        to_sample(); to_next();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            to_sample();
            chk($sformatf("tg_on%0d", k), {o_data_lo, o_data_hi, o_load, o_shift, o_bit_index},
                {a_lo[k], a_hi[k], 2'b11, 3'(k)});
            to_next();
            if (k < 7) begin
                drive(0, 0, 0, 0, 0, 0);
                to_sample();
                chk($sformatf("tg_off%0d", k), {o_load, o_shift, o_busy, o_bit_index},
                    {3'b001, 3'(k + 1)});
                to_next();
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        to_sample();
        chk("tg_idle", o_busy, 0);
        to_next();

        // Async reset at bit 4 with a tile waiting in the buffer.
        drive(1, 8'hAA, 8'h55, 3, 0, 0);
        to_sample(); to_next();
        drive(1, 8'h11, 8'h22, 1, 1, 0);
        to_sample(); to_next();
        for (int k = 1; k < 4; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            to_sample(); to_next();
        end
        to_sample();
        chk("rs_pre_idx", o_bit_index, 4);
        chk("rs_pre_ready", tif.o_tile_ready, 0);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("rs_ready", tif.o_tile_ready, 1);
        chk("rs_strobes", {o_load, o_shift}, 0);
        chk("rs_data", {o_data_lo, o_data_hi}, 0);
        chk("rs_meta", {o_palette, o_bit_index, o_busy, o_underrun}, 0);
        to_next();
        drive(0, 0, 0, 0, 0, 0);
        @(posedge i_clk);
        i_reset_n = 1'b1;
        to_next();
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            to_sample();
            chk($sformatf("rs_after%0d", k), {o_load, o_busy, o_data_lo, o_data_hi}, 0);
            to_next();
        end
        chk("rs_no_underrun", o_underrun, 0);

        // Underrun: tile, then two extra enabled cycles in IDLE.
        drive(1, 8'h12, 8'h34, 1, 0, 0);
        to_sample(); to_next();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            to_sample();
            if (k == 7) chk("ur_before", o_underrun, 0);
            to_next();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            to_sample(); to_next();
        end
        drive(0, 0, 0, 0, 0, 0);
        to_sample();
        chk("ur_set", o_underrun, UR_EXP);
        to_next();
        to_sample();
        chk("ur_sticky", o_underrun, UR_EXP);
        to_next();
        drive(0, 0, 0, 0, 1, 1);
        to_sample(); to_next();
        drive(0, 0, 0, 0, 0, 0);
        to_sample();
        chk("ur_cleared", o_underrun, 0);
        to_next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
